pipe_control_unit: RTL
======================

# pipe_control_unit

Registered, parametrised instruction-decode control stage with valid/ready handshakes on both sides. Each accepted opcode and register fields become a registered control bundle for the execute stage. The stage detects load-use hazards against the instruction it holds, inserting exactly one bubble. It also handles flush from branch resolution and halts on illegal opcodes until flushed. It sits between instruction fetch and the execute/memory datapath.

## Interface
- OP_CODE_BITS, 6, opcode field width (≥4)
- ALU_OP_BITS, 4, ALU operation code width
- MEM_OP_BITS, 2, memory op width (00 none, 01 load, 10 store)
- REG_ADDR_BITS, 5, register index width
- CNT_BITS, 16, performance counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- opcode  in  OP_CODE_BITS  instruction opcode
- rs, rt, rd  in  REG_ADDR_BITS each  source/target/dest fields
- flush  in  1  branch/jump redirect; kill held and incoming instruction
- out_valid  out  1  control bundle valid
- out_ready  in  1  execute consumes bundle
- reg_write, mem_to_reg, alu_src, beq, bne, jump, address_src  out  1 each  registered controls
- alu_op  out  ALU_OP_BITS  registered
- mem_op  out  MEM_OP_BITS  registered
- dst_addr  out  REG_ADDR_BITS  rd if R-type else rt; 0 when reg_write=0
- illegal  out  1  high while in HALT
- stall_cnt, flush_cnt  out  CNT_BITS each  performance counters

## Operation
- Decode map: 0 add, 1 addi, 2 sub, 3 subi, 4 not, 5 and, 6 or, 7 nand, 8 nor, 9 mov, 10 li, 11 lw, 12 sw, 13 beq, 14 bne, 15 jump. Opcodes ≥16 are illegal.
- R-type (rt read, dst=rd): 0, 2, 4–8. rt is also read by sw, beq, bne.
- alu_op: add/addi/lw/sw 0000, sub/subi/beq/bne 0001, not 0010, and 0011, or 0100, nand 0101, nor 0110, mov 0111, li 1000.
- beq, bne and jump do not write a register. Every field of the bundle is fully defined for every opcode, with no latched leftovers.
- advance = !out_valid | out_ready.
- hazard condition: out_valid & mem_op==01 & dst_addr≠0 & in_valid & (rs==dst_addr | (reads_rt & rt==dst_addr)).
- FSM states:
  - RUN:
    - On flush: clear out_valid and drop input.
    - On in_valid & advance & hazard: load a bubble (out_valid=0, bundle zeroed) → BUBBLE.
    - On in_valid & advance & illegal opcode: consume it, out_valid=0 → HALT.
    - Else, on in_valid & advance: register the bundle with out_valid=1.
  - BUBBLE: one cycle with in_ready=0 → RUN. A flush here → RUN.
  - HALT: in_ready=0, out_valid=0, illegal=1. Only flush → RUN.
- in_ready = (state==RUN) & advance & !hazard & !flush.

## Timing
- Reset: state RUN, out_valid 0, all bundle fields 0, dst_addr 0, illegal 0, counters 0. in_ready is 1 on the first cycle after release.
- Latency: accept at edge N → bundle valid after edge N; throughput 1/cycle with no hazards.
- Held bundle is stable while out_valid & !out_ready.
- Load-use costs exactly one bubble cycle.
- Flush has priority over hazard, illegal and accept in the same cycle.
- Reset asserted mid-operation clears everything asynchronously; no partial bundle survives.

## Configuration
- CTRL_PERF_EN defined: stall_cnt increments on each hazard bubble inserted, flush_cnt on each cycle with flush=1. Both counters saturate at all-ones.
- CTRL_PERF_EN undefined: counter logic is removed and both ports are tied to 0.

## Structure
- Package ctrl_pkg holds:
  - the opcode enum
  - alu_op and mem_op constants
  - the control bundle struct
  - the FSM state enum
- Sub-module ctrl_decode: purely combinational opcode → bundle, illegal and reads_rt. The top holds the FSM, output register, hazard check and counters.

## Test plan
- Back-to-back add, sub, addi with out_ready=1 → one bundle per cycle. Checks: add alu_op 0000, reg_write 1; addi alu_src 1; dst_addr = rd/rd/rt.
- lw r3, then add reading rs=3 → exactly one cycle of out_valid=0, in_ready=0; add issues next. stall_cnt=1 with CTRL_PERF_EN. lw to r0 → no bubble.
- out_ready=0 for 3 cycles with a valid bundle → bundle and in_ready=0 held; release → resumes with no drop or duplicate.
- Opcode 20 → illegal=1, in_ready=0 indefinitely; flush → RUN, next add accepted. flush_cnt=1.
- flush in the same cycle as in_valid with a hazard → out_valid=0, input dropped, state RUN.
- rst_n low mid-stream for one cycle → all outputs 0 immediately; in_ready=1 after release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the decode control stage: opcodes, ALU/memory encodings,
// the registered control bundle and the stage FSM states.
package ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_ADDI = 4'd1,  OP_SUB  = 4'd2,  OP_SUBI = 4'd3,
    OP_NOT  = 4'd4,  OP_AND  = 4'd5,  OP_OR   = 4'd6,  OP_NAND = 4'd7,
    OP_NOR  = 4'd8,  OP_MOV  = 4'd9,  OP_LI   = 4'd10, OP_LW   = 4'd11,
    OP_SW   = 4'd12, OP_BEQ  = 4'd13, OP_BNE  = 4'd14, OP_JUMP = 4'd15
  } opcode_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_NOT  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_NAND = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_MOV  = 4'b0111;
  localparam logic [3:0] ALU_LI   = 4'b1000;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       beq;
    logic       bne;
    logic       jump;
    logic       address_src;
    logic [3:0] alu_op;
    logic [1:0] mem_op;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle, destination register,
// illegal-opcode flag and whether the instruction reads rt.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_CODE_BITS  = 6,
  parameter int REG_ADDR_BITS = 5
) (
  input  logic [OP_CODE_BITS-1:0]  opcode,
  input  logic [REG_ADDR_BITS-1:0] rt,
  input  logic [REG_ADDR_BITS-1:0] rd,
  output ctrl_t                    ctrl,
  output logic [REG_ADDR_BITS-1:0] dst_addr,
  output logic                     illegal,
  output logic                     reads_rt
);

  logic r_type;

  always_comb begin
    ctrl     = '0;
    r_type   = 1'b0;
    reads_rt = 1'b0;
    dst_addr = '0;
    illegal  = (opcode > OP_CODE_BITS'(15));
    case (opcode_e'(opcode[3:0]))
      OP_ADD:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD;  r_type = 1'b1; end
      OP_ADDI: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD;  ctrl.alu_src = 1'b1; end
      OP_SUB:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB;  r_type = 1'b1; end
      OP_SUBI: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB;  ctrl.alu_src = 1'b1; end
      OP_NOT:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_NOT;  r_type = 1'b1; end
      OP_AND:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND;  r_type = 1'b1; end
      OP_OR:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;   r_type = 1'b1; end
      OP_NAND: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_NAND; r_type = 1'b1; end
      OP_NOR:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_NOR;  r_type = 1'b1; end
      OP_MOV:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_MOV; end
      OP_LI:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_LI;   ctrl.alu_src = 1'b1; end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_op     = MEM_LOAD;
      end
      OP_SW:   begin ctrl.alu_src = 1'b1; ctrl.mem_op = MEM_STORE; reads_rt = 1'b1; end
      OP_BEQ:  begin ctrl.beq = 1'b1; ctrl.alu_op = ALU_SUB; reads_rt = 1'b1; end
      OP_BNE:  begin ctrl.bne = 1'b1; ctrl.alu_op = ALU_SUB; reads_rt = 1'b1; end
      OP_JUMP: begin ctrl.jump = 1'b1; ctrl.address_src = 1'b1; end
      default: ctrl = '0;
    endcase
    // Illegal opcodes never reach execute, so keep their bundle clean.
    if (illegal) begin
      ctrl     = '0;
      r_type   = 1'b0;
      reads_rt = 1'b0;
    end
    reads_rt = reads_rt | r_type;
    if (ctrl.reg_write) dst_addr = r_type ? rd : rt;
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Registered decode control stage with load-use bubble, flush and illegal halt.
// Optional CTRL_PERF_EN enables saturating stall/flush performance counters.
module pipe_control_unit
  import ctrl_pkg::*;
#(
  parameter int OP_CODE_BITS  = 6,
  parameter int ALU_OP_BITS   = 4,
  parameter int MEM_OP_BITS   = 2,
  parameter int REG_ADDR_BITS = 5,
  parameter int CNT_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_CODE_BITS-1:0]  opcode,
  input  logic [REG_ADDR_BITS-1:0] rs,
  input  logic [REG_ADDR_BITS-1:0] rt,
  input  logic [REG_ADDR_BITS-1:0] rd,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     reg_write,
  output logic                     mem_to_reg,
  output logic                     alu_src,
  output logic                     beq,
  output logic                     bne,
  output logic                     jump,
  output logic                     address_src,
  output logic [ALU_OP_BITS-1:0]   alu_op,
  output logic [MEM_OP_BITS-1:0]   mem_op,
  output logic [REG_ADDR_BITS-1:0] dst_addr,
  output logic                     illegal,
  output logic [CNT_BITS-1:0]      stall_cnt,
  output logic [CNT_BITS-1:0]      flush_cnt,
  output logic [1:0]               state_dbg
);

  // Valid/ready: a transfer occurs on a rising edge where valid and ready are
  // both high; out_valid never depends on out_ready, and a held bundle stays
  // unchanged until it transfers.

  ctrl_t                    dec_ctrl, ctrl_q;
  logic [REG_ADDR_BITS-1:0] dec_dst, dst_q;
  logic                     dec_illegal, dec_reads_rt;
  state_e                   state, state_n;
  logic                     advance, hazard, load, clear;

  ctrl_decode #(
    .OP_CODE_BITS (OP_CODE_BITS),
    .REG_ADDR_BITS(REG_ADDR_BITS)
  ) u_decode (
    .opcode  (opcode),
    .rt      (rt),
    .rd      (rd),
    .ctrl    (dec_ctrl),
    .dst_addr(dec_dst),
    .illegal (dec_illegal),
    .reads_rt(dec_reads_rt)
  );

  assign advance = !out_valid || out_ready;
  assign hazard  = out_valid && (ctrl_q.mem_op == MEM_LOAD) && (dst_q != '0) && in_valid &&
                   ((rs == dst_q) || (dec_reads_rt && (rt == dst_q)));
  assign in_ready = (state == ST_RUN) && advance && !hazard && !flush;

  always_comb begin
    state_n = state;
    load    = 1'b0;
    clear   = 1'b0;
    case (state)
      ST_RUN: begin
        if (flush) begin
          clear = 1'b1;
        end else if (in_valid && advance && hazard) begin
          clear   = 1'b1;
          state_n = ST_BUBBLE;
        end else if (in_valid && advance && dec_illegal) begin
          clear   = 1'b1;
          state_n = ST_HALT;
        end else if (in_valid && advance) begin
          load = 1'b1;
        end else if (advance) begin
          clear = 1'b1;
        end
      end
      ST_BUBBLE: begin
        clear   = 1'b1;
        state_n = ST_RUN;
      end
      ST_HALT: begin
        clear = 1'b1;
        if (flush) state_n = ST_RUN;
      end
      default: begin
        clear   = 1'b1;
        state_n = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      dst_q     <= '0;
    end else begin
      state <= state_n;
      if (clear) begin
        out_valid <= 1'b0;
        ctrl_q    <= '0;
        dst_q     <= '0;
      end else if (load) begin
        out_valid <= 1'b1;
        ctrl_q    <= dec_ctrl;
        dst_q     <= dec_dst;
      end
    end
  end

  assign reg_write   = ctrl_q.reg_write;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign alu_src     = ctrl_q.alu_src;
  assign beq         = ctrl_q.beq;
  assign bne         = ctrl_q.bne;
  assign jump        = ctrl_q.jump;
  assign address_src = ctrl_q.address_src;
  assign alu_op      = ALU_OP_BITS'(ctrl_q.alu_op);
  assign mem_op      = MEM_OP_BITS'(ctrl_q.mem_op);
  assign dst_addr    = dst_q;
  assign illegal     = (state == ST_HALT);
  assign state_dbg   = state;

`ifdef CTRL_PERF_EN
  logic bubble_ins;
  assign bubble_ins = (state == ST_RUN) && !flush && advance && hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bubble_ins && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1))      flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
